// File: rtl/rdshift_reg.sv
// Universal WIDTH-bit register with hold / shift right / shift left / parallel load.
// A saturating shift counter and Empty flag let it serve as a parallel-to-serial converter.
`timescale 1ns/10ps
module rdshift_reg #(
  parameter int unsigned WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int unsigned CW = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             nRst,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] D,
  input  logic             SIR,
  input  logic             SIL,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] nQ,
  output logic             SOR,
  output logic             SOL,
  output logic [CW-1:0]    Count,
  output logic             Empty
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam logic [CW-1:0] COUNT_FULL = CW'(WIDTH);

  logic [WIDTH-1:0] q_nxt;
  logic [CW-1:0]    count_nxt;
  logic [CW-1:0]    count_inc;

  // Count sticks at WIDTH once the word has been fully shifted out.
  assign count_inc = (Count == COUNT_FULL) ? COUNT_FULL : Count + CW'(1);

  always_comb begin
    q_nxt     = Q;
    count_nxt = Count;
    case (Mode)
      MODE_HOLD: begin
        q_nxt     = Q;
        count_nxt = Count;
      end
      MODE_RIGHT: begin
        q_nxt     = {SIR, Q[WIDTH-1:1]};
        count_nxt = count_inc;
      end
      MODE_LEFT: begin
        q_nxt     = {Q[WIDTH-2:0], SIL};
        count_nxt = count_inc;
      end
      MODE_LOAD: begin
        q_nxt     = D;
        count_nxt = '0;
      end
      default: begin
        q_nxt     = Q;
        count_nxt = Count;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      Q     <= RESET_VALUE;
      Count <= COUNT_FULL;
    end else begin
      Q     <= q_nxt;
      Count <= count_nxt;
    end
  end

  // Complement, serial outs and Empty are views of the stored state, not extra state.
  assign nQ    = ~Q;
  assign SOR   = Q[0];
  assign SOL   = Q[WIDTH-1];
  assign Empty = (Count == COUNT_FULL);

endmodule

// File: tb/tb_rdshift_reg.sv
// Scoreboard bench for rdshift_reg at WIDTH=8, 2 and 32.
`timescale 1ns/10ps
module tb_rdshift_reg;

  typedef struct {
    logic [31:0] q;
    int          cnt;
  } exp_t;

  int total = 0;
  int bad   = 0;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic nrst = 1'b1;

  logic [1:0] mode8 = 2'b00;
  logic [7:0] d8 = '0;
  logic       sir8 = 1'b0, sil8 = 1'b0;
  logic [7:0] q8, nq8;
  logic       sor8, sol8, empty8;
  logic [3:0] cnt8;

  logic [1:0] mode2 = 2'b00;
  logic [1:0] d2 = '0;
  logic       sir2 = 1'b0, sil2 = 1'b0;
  logic [1:0] q2, nq2;
  logic       sor2, sol2, empty2;
  logic [1:0] cnt2;

  logic [1:0]  mode32 = 2'b00;
  logic [31:0] d32 = '0;
  logic        sir32 = 1'b0, sil32 = 1'b0;
  logic [31:0] q32, nq32;
  logic        sor32, sol32, empty32;
  logic [5:0]  cnt32;

  exp_t sb8[$];
  exp_t sb2[$];
  exp_t sb32[$];

  logic [7:0] m_q8;
  int         m_cnt8;

  rdshift_reg #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut8 (
    .Clk(clk), .nRst(nrst), .Mode(mode8), .D(d8), .SIR(sir8), .SIL(sil8),
    .Q(q8), .nQ(nq8), .SOR(sor8), .SOL(sol8), .Count(cnt8), .Empty(empty8));

  rdshift_reg #(.WIDTH(2), .RESET_VALUE(2'b10)) dut2 (
    .Clk(clk), .nRst(nrst), .Mode(mode2), .D(d2), .SIR(sir2), .SIL(sil2),
    .Q(q2), .nQ(nq2), .SOR(sor2), .SOL(sol2), .Count(cnt2), .Empty(empty2));

  rdshift_reg #(.WIDTH(32), .RESET_VALUE(32'hDEADBEEF)) dut32 (
    .Clk(clk), .nRst(nrst), .Mode(mode32), .D(d32), .SIR(sir32), .SIL(sil32),
    .Q(q32), .nQ(nq32), .SOR(sor32), .SOL(sol32), .Count(cnt32), .Empty(empty32));

  // Gated clock so the reset test can run with Clk stopped.
  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one 8-bit operation and push the model's expected post-edge state.
  task automatic push8(input logic [1:0] m, input logic [7:0] d,
                       input logic sir, input logic sil);
    exp_t e;
    mode8 = m; d8 = d; sir8 = sir; sil8 = sil;
    case (m)
      2'b01: begin m_q8 = {sir, m_q8[7:1]}; if (m_cnt8 < 8) m_cnt8++; end
      2'b10: begin m_q8 = {m_q8[6:0], sil}; if (m_cnt8 < 8) m_cnt8++; end
      2'b11: begin m_q8 = d; m_cnt8 = 0; end
      default: ;
    endcase
    e.q = 32'(m_q8);
    e.cnt = m_cnt8;
    sb8.push_back(e);
  endtask

  task automatic test_reset();
    clk_en = 1'b0;
    #3 nrst = 1'b0;
    #2;
    total++; if (q8 !== 8'hA5) begin bad++; $display("FAIL reset_q: got %h want a5", q8); end
    total++; if (nq8 !== 8'h5A) begin bad++; $display("FAIL reset_nq: got %h want 5a", nq8); end
    total++; if (cnt8 !== 4'd8) begin bad++; $display("FAIL reset_count: got %0d want 8", cnt8); end
    total++; if (empty8 !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", empty8); end
    total++; if ({sol8, sor8} !== 2'b11) begin bad++; $display("FAIL reset_so: got %b want 11", {sol8, sor8}); end
    total++; if (q2 !== 2'b10 || cnt2 !== 2'd2 || empty2 !== 1'b1) begin
      bad++; $display("FAIL reset_w2: got q=%b cnt=%0d empty=%b want q=10 cnt=2 empty=1", q2, cnt2, empty2);
    end
    total++; if (q32 !== 32'hDEADBEEF || cnt32 !== 6'd32 || empty32 !== 1'b1) begin
      bad++; $display("FAIL reset_w32: got q=%h cnt=%0d empty=%b want q=deadbeef cnt=32 empty=1", q32, cnt32, empty32);
    end
    m_q8 = 8'hA5;
    m_cnt8 = 8;
    #2 nrst = 1'b1;
    #3 clk_en = 1'b1;
  endtask

  task automatic test_load_hold();
    exp_t e;
    push8(2'b11, 8'h3C, 1'b0, 1'b0);
    tick();
    e = sb8.pop_front();
    total++; if (q8 !== e.q[7:0]) begin bad++; $display("FAIL load_q: got %h want %h", q8, e.q[7:0]); end
    total++; if (nq8 !== 8'hC3) begin bad++; $display("FAIL load_nq: got %h want c3", nq8); end
    total++; if (cnt8 !== 4'(e.cnt) || empty8 !== 1'b0) begin
      bad++; $display("FAIL load_count: got cnt=%0d empty=%b want cnt=%0d empty=0", cnt8, empty8, e.cnt);
    end
    for (int i = 0; i < 5; i++) begin
      push8(2'b00, 8'hFF, 1'b1, 1'b1);
      tick();
      e = sb8.pop_front();
      total++; if (q8 !== 8'h3C || q8 !== e.q[7:0] || cnt8 !== 4'd0) begin
        bad++; $display("FAIL hold[%0d]: got q=%h cnt=%0d want q=3c cnt=0", i, q8, cnt8);
      end
    end
  endtask

  task automatic test_serialise_right();
    exp_t e;
    logic [7:0] sor_seq;
    sor_seq = 8'hB4;
    push8(2'b11, 8'hB4, 1'b0, 1'b0);
    tick();
    e = sb8.pop_front();
    total++; if (q8 !== e.q[7:0]) begin bad++; $display("FAIL ser_load: got %h want %h", q8, e.q[7:0]); end
    for (int i = 0; i < 8; i++) begin
      total++; if (sor8 !== sor_seq[i]) begin bad++; $display("FAIL ser_sor[%0d]: got %b want %b", i, sor8, sor_seq[i]); end
      push8(2'b01, 8'h00, 1'b1, 1'b0);
      tick();
      e = sb8.pop_front();
      total++; if (q8 !== e.q[7:0] || nq8 !== ~e.q[7:0]) begin
        bad++; $display("FAIL ser_q[%0d]: got q=%h nq=%h want q=%h", i, q8, nq8, e.q[7:0]);
      end
      total++; if (cnt8 !== 4'(i + 1) || empty8 !== (i == 7)) begin
        bad++; $display("FAIL ser_count[%0d]: got cnt=%0d empty=%b want cnt=%0d empty=%b", i, cnt8, empty8, i + 1, (i == 7));
      end
    end
    total++; if (q8 !== 8'hFF) begin bad++; $display("FAIL ser_final: got %h want ff", q8); end
  endtask

  task automatic test_saturation();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      push8(2'b10, 8'h00, 1'b1, 1'b0);
      tick();
      e = sb8.pop_front();
      total++; if (q8 !== e.q[7:0] || cnt8 !== 4'd8 || empty8 !== 1'b1) begin
        bad++; $display("FAIL sat[%0d]: got q=%h cnt=%0d empty=%b want q=%h cnt=8 empty=1", i, q8, cnt8, empty8, e.q[7:0]);
      end
    end
    total++; if (q8 !== 8'hF8 || sol8 !== 1'b1 || sor8 !== 1'b0) begin
      bad++; $display("FAIL sat_final: got q=%h sol=%b sor=%b want q=f8 sol=1 sor=0", q8, sol8, sor8);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    push8(2'b11, 8'h81, 1'b0, 1'b0);
    tick();
    e = sb8.pop_front();
    for (int i = 0; i < 3; i++) begin
      push8(2'b01, 8'h00, 1'b0, 1'b0);
      tick();
      e = sb8.pop_front();
    end
    total++; if (q8 !== 8'h10 || cnt8 !== 4'd3) begin
      bad++; $display("FAIL mid_pre: got q=%h cnt=%0d want q=10 cnt=3", q8, cnt8);
    end
    #2 nrst = 1'b0;
    #1;
    total++; if (q8 !== 8'hA5 || cnt8 !== 4'd8 || empty8 !== 1'b1) begin
      bad++; $display("FAIL mid_reset: got q=%h cnt=%0d empty=%b want q=a5 cnt=8 empty=1", q8, cnt8, empty8);
    end
    mode8 = 2'b11; d8 = 8'hFF;
    tick();
    total++; if (q8 !== 8'hA5 || cnt8 !== 4'd8) begin
      bad++; $display("FAIL mid_held: got q=%h cnt=%0d want q=a5 cnt=8", q8, cnt8);
    end
    m_q8 = 8'hA5;
    m_cnt8 = 8;
    nrst = 1'b1;
    push8(2'b11, 8'h0F, 1'b0, 1'b0);
    tick();
    e = sb8.pop_front();
    total++; if (q8 !== e.q[7:0] || q8 !== 8'h0F || cnt8 !== 4'd0 || empty8 !== 1'b0) begin
      bad++; $display("FAIL mid_reload: got q=%h cnt=%0d empty=%b want q=0f cnt=0 empty=0", q8, cnt8, empty8);
    end
  endtask

  task automatic test_random_mix();
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      push8(2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom), 1'($urandom));
      tick();
      e = sb8.pop_front();
      total++; if (q8 !== e.q[7:0] || nq8 !== ~e.q[7:0] || sol8 !== e.q[7] || sor8 !== e.q[0]) begin
        bad++; $display("FAIL mix_q[%0d]: got q=%h nq=%h want q=%h", i, q8, nq8, e.q[7:0]);
      end
      total++; if (cnt8 !== 4'(e.cnt) || empty8 !== (e.cnt == 8)) begin
        bad++; $display("FAIL mix_count[%0d]: got cnt=%0d empty=%b want cnt=%0d", i, cnt8, empty8, e.cnt);
      end
    end
  endtask

  task automatic test_width_sweep();
    exp_t e2, e32;
    logic [1:0]  m2;
    logic [31:0] m32;
    int c2, c32;
    logic s;
    m2 = 2'b01;
    m32 = $urandom;
    c2 = 0; c32 = 0;
    mode2 = 2'b11; d2 = m2;
    mode32 = 2'b11; d32 = m32;
    e2.q = 32'(m2); e2.cnt = 0; sb2.push_back(e2);
    e32.q = m32; e32.cnt = 0; sb32.push_back(e32);
    tick();
    e2 = sb2.pop_front();
    e32 = sb32.pop_front();
    total++; if (q2 !== e2.q[1:0] || cnt2 !== 2'd0 || empty2 !== 1'b0) begin
      bad++; $display("FAIL w2_load: got q=%b cnt=%0d empty=%b want q=%b cnt=0 empty=0", q2, cnt2, empty2, e2.q[1:0]);
    end
    total++; if (q32 !== e32.q || cnt32 !== 6'd0 || empty32 !== 1'b0) begin
      bad++; $display("FAIL w32_load: got q=%h cnt=%0d empty=%b want q=%h cnt=0 empty=0", q32, cnt32, empty32, e32.q);
    end
    for (int k = 1; k <= 32; k++) begin
      s = 1'($urandom);
      mode2 = 2'b01; sir2 = s;
      mode32 = 2'b01; sir32 = ~s;
      m2 = {s, m2[1]};
      if (c2 < 2) c2++;
      m32 = {~s, m32[31:1]};
      if (c32 < 32) c32++;
      e2.q = 32'(m2); e2.cnt = c2; sb2.push_back(e2);
      e32.q = m32; e32.cnt = c32; sb32.push_back(e32);
      tick();
      e2 = sb2.pop_front();
      e32 = sb32.pop_front();
      total++; if (q2 !== e2.q[1:0] || nq2 !== ~e2.q[1:0] || sor2 !== e2.q[0]) begin
        bad++; $display("FAIL w2_q[%0d]: got q=%b nq=%b want q=%b", k, q2, nq2, e2.q[1:0]);
      end
      total++; if (cnt2 !== 2'(e2.cnt) || empty2 !== (k >= 2)) begin
        bad++; $display("FAIL w2_count[%0d]: got cnt=%0d empty=%b want cnt=%0d empty=%b", k, cnt2, empty2, e2.cnt, (k >= 2));
      end
      total++; if (q32 !== e32.q || nq32 !== ~e32.q || sor32 !== e32.q[0]) begin
        bad++; $display("FAIL w32_q[%0d]: got q=%h nq=%h want q=%h", k, q32, nq32, e32.q);
      end
      total++; if (cnt32 !== 6'(e32.cnt) || empty32 !== (k == 32)) begin
        bad++; $display("FAIL w32_count[%0d]: got cnt=%0d empty=%b want cnt=%0d empty=%b", k, cnt32, empty32, e32.cnt, (k == 32));
      end
    end
    mode2 = 2'b00; mode32 = 2'b00;
  endtask

  initial begin
    test_reset();
    test_load_hold();
    test_serialise_right();
    test_saturation();
    test_reset_mid();
    test_random_mix();
    test_width_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rdshift_reg.md
# rdshift_reg

Parametrised WIDTH-bit edge-triggered register generalising the single-bit reset D-type into a universal register. Modes: hold, shift right, shift left and parallel load. Complementary outputs Q/nQ are kept from the single-bit cell. A shift counter and Empty flag let the block act as a parallel-to-serial converter for downstream serial logic. It sits wherever the design needs a multi-bit reset-able store or serialiser clocked from the common Clk.

## Interface
- WIDTH, 8, register width in bits; legal range 2..32.
- RESET_VALUE, 0, value loaded into Q on reset (WIDTH bits).
- CW, $clog2(WIDTH+1), width of Count (derived, not overridden).

- Clk  input  1  clock, rising-edge active.
- nRst  input  1  reset; asynchronous, active-low.
- Mode  input  2  operation select:
  - 00 = hold
  - 01 = shift right
  - 10 = shift left
  - 11 = parallel load
- D  input  WIDTH  parallel load data; sampled only when Mode=11.
- SIR  input  1  serial in for right shift; enters Q[WIDTH-1].
- SIL  input  1  serial in for left shift; enters Q[0].
- Q  output  WIDTH  register contents.
- nQ  output  WIDTH  bitwise complement of Q at all times.
- SOR  output  1  Q[0]; right-shift serial out.
- SOL  output  1  Q[WIDTH-1]; left-shift serial out.
- Count  output  CW  shifts performed since last load; saturates at WIDTH.
- Empty  output  1  high when Count == WIDTH.

## Operation
- Reset (nRst=0): immediately, with no Clk edge required:
  - Q = RESET_VALUE, nQ = ~RESET_VALUE
  - Count = WIDTH, Empty = 1
  - SOR/SOL follow Q
  - Held while nRst=0; all inputs ignored.
- State per rising Clk edge with nRst=1:
  - Mode=00: Q and Count unchanged.
  - Mode=01: Q <= {SIR, Q[WIDTH-1:1]}; Count <= min(Count+1, WIDTH).
  - Mode=10: Q <= {Q[WIDTH-2:0], SIL}; Count <= min(Count+1, WIDTH).
  - Mode=11: Q <= D; Count <= 0.
- Empty is combinational from Count (Count == WIDTH). A load deasserts it at the same edge that updates Q.
- Shifting with Empty=1 is legal: Q keeps shifting and Count stays at WIDTH (no wrap to 0).
- Mixed left/right shifts each increment Count; direction is not tracked.
- nQ, SOR and SOL are pure combinational functions of Q; there is no separate state for them.
- X/Z on Mode during an edge is a bench error; the RTL need not define the result.

## Timing
- Latency: one Clk edge from Mode/D/SIR/SIL sampled to new Q/Count visible.
- Inputs must be stable setup/hold around the rising edge (1 ns nominal in sim, timeprecision 10 ps).
- Reset assertion acts asynchronously. Deassertion must be clean relative to Clk; the first edge after deassertion performs the Mode operation normally.
- Reset asserted mid-serialisation aborts it: Count returns to WIDTH and Q to RESET_VALUE at once, with no partial update on a coincident edge.
- Serialising a word: load at edge 0, then WIDTH shift edges.
  - Empty rises on edge WIDTH.
  - SOR presents bit i during the cycle after edge i (i = 0..WIDTH-1), LSB first.

## Test plan
- Reset: WIDTH=8, RESET_VALUE=8'hA5, nRst=0 mid-cycle with Clk stopped → Q=A5, nQ=5A, Count=8, Empty=1 without any edge.
- Load/hold: nRst=1, Mode=11, D=8'h3C, one edge → Q=3C, nQ=C3, Count=0, Empty=0. Mode=00 for 5 edges → Q stays 3C, Count 0.
- Serialise right: from Q=8'hB4, Mode=01, SIR=1, 8 edges → SOR sequence 0,0,1,0,1,1,0,1; Count 1..8; Empty rises on 8th edge; Q=FF.
- Saturation/left shift: after the above, Mode=10, SIL=0, 3 more edges → Q=F8, Count stays 8, Empty stays 1.
- Reset mid-operation: load 8'h81, shift right 3 edges (Count=3), pull nRst low between edges → Q=RESET_VALUE, Count=8 immediately. Release and load 8'h0F → Q=0F, Count=0.
- Width sweep: repeat the load + full shift-right scenario for WIDTH=2 and WIDTH=32 → Empty after exactly WIDTH shifts; nQ == ~Q on every edge.
